// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: four-digit multiplexed seven-segment scan controller.
// A configuration (digits, decimal points, digit enables, brightness) is taken
// over a valid/ready handshake into a pending slot and becomes active at the
// next frame boundary. Each digit slot is 16 scan ticks: one guard tick with
// all anodes off, then `bright` lit ticks, then dark ticks. All pins registered.
// Optional build macro: SEVSEG_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digits 3..1) together with their decimal points.
module seven_seg_scan_ctrl #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_digits,
  input  logic [3:0]  cfg_dp,
  input  logic [3:0]  cfg_digit_en,
  input  logic [3:0]  cfg_bright,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_start
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [3:0]  bright;
  } cfg_t;

  typedef enum logic [1:0] {
    GUARD = 2'd0,
    ON    = 2'd1,
    OFF   = 2'd2
  } phase_t;

  logic [PW-1:0] presc_q;
  logic          tick;
  logic [3:0]    st_q;
  logic [1:0]    d_q;
  logic          wrap;
  phase_t        phase_q, phase_d;

  cfg_t          act_q;
  cfg_t          pend_q;
  logic          pend_v_q;
  logic          ready_q;
  logic          accept;
  cfg_t          cfg_in;

  logic [3:0]    cur_nib;
  logic          cur_dp;
  logic          cur_en;
  logic          lz_blank;
  logic          lit;

  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_n_q, dp_n_d;
  logic          fs_q;

  // Active-low hex decode, segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick   = (presc_q == PW'(TICK_DIV - 1));
  assign wrap   = tick && (st_q == 4'hF) && (d_q == 2'd3);
  assign accept = cfg_valid && ready_q;
  assign cfg_in = '{digits: cfg_digits, dp: cfg_dp, en: cfg_digit_en, bright: cfg_bright};

  // Prescaler: free-running 0..TICK_DIV-1, tick on terminal count.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Slot tick counter and digit index; both wrap naturally at their widths.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      st_q <= '0;
      d_q  <= '0;
    end else if (tick) begin
      st_q <= st_q + 4'd1;
      if (st_q == 4'hF) begin
        d_q <= d_q + 2'd1;
      end
    end
  end

  // Slot phase register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      phase_q <= GUARD;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase of the upcoming tick: guard on slot entry, lit while st <= bright.
  // The active config only changes when st returns to 0, so the bright value
  // seen here is stable for the whole slot.
  always_comb begin
    phase_d = phase_q;
    if (tick) begin
      if (st_q == 4'hF) begin
        phase_d = GUARD;
      end else if ((st_q + 4'd1) <= act_q.bright) begin
        phase_d = ON;
      end else begin
        phase_d = OFF;
      end
    end
  end

  // Configuration path: pending slot filled by handshake, moved to active at frame wrap.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      act_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      if (wrap && pend_v_q) begin
        act_q <= pend_q;
      end
      if (accept) begin
        pend_q <= cfg_in;
      end
      // An accept on the wrap edge keeps the slot full so it waits a frame.
      if (accept) begin
        pend_v_q <= 1'b1;
      end else if (wrap) begin
        pend_v_q <= 1'b0;
      end
    end
  end

  // Ready drops on accept and reopens the cycle after the frame_start pulse.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ready_q <= 1'b1;
    end else if (accept) begin
      ready_q <= 1'b0;
    end else if (fs_q && !pend_v_q) begin
      ready_q <= 1'b1;
    end
  end

  // Select the nibble, decimal point and enable of the digit being scanned.
  always_comb begin
    cur_nib = act_q.digits[{d_q, 2'b00} +: 4];
    cur_dp  = act_q.dp[d_q];
    cur_en  = act_q.en[d_q];
  end

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  // Leading-zero blanking: a digit is dark if it and every higher nibble is zero.
  always_comb begin
    lz_blank = 1'b0;
    case (d_q)
      2'd3:    lz_blank = (act_q.digits[15:12] == 4'h0);
      2'd2:    lz_blank = (act_q.digits[15:8] == 8'h00);
      2'd1:    lz_blank = (act_q.digits[15:4] == 12'h000);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Next pin values: only a lit anode carries segment and decimal-point data.
  always_comb begin
    lit    = (phase_q == ON) && cur_en && !lz_blank;
    an_d   = '1;
    seg_d  = '1;
    dp_n_d = 1'b1;
    if (lit) begin
      an_d[d_q] = 1'b0;
      seg_d     = hex_to_seg(cur_nib);
      dp_n_d    = ~cur_dp;
    end
  end

  // Output registers, including the frame_start pulse on the wrap edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      an_q   <= '1;
      seg_q  <= '1;
      dp_n_q <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_n_q <= dp_n_d;
      fs_q   <= wrap;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign frame_start = fs_q;
  assign cfg_ready   = ready_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with a short scan tick. Expected pins are
// computed from elapsed cycle count and the history of accepted configs.
module tb_seven_seg_scan_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned F  = 64 * TD;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_digits = '0;
  logic [3:0]  cfg_dp = '0;
  logic [3:0]  cfg_digit_en = '0;
  logic [3:0]  cfg_bright = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_start;

  seven_seg_scan_ctrl #(.TICK_DIV(TD)) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_digits   (cfg_digits),
    .cfg_dp       (cfg_dp),
    .cfg_digit_en (cfg_digit_en),
    .cfg_bright   (cfg_bright),
    .an           (an),
    .seg          (seg),
    .dp_n         (dp_n),
    .frame_start  (frame_start)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [3:0]  br;
    int unsigned acc;
  } mcfg_t;

  mcfg_t acc_q[$];
  int unsigned cyc;
  int checks = 0;
  int failures = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Rising edges since reset release.
  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned next_wrap(input int unsigned a);
    return (a / F + 1) * F;
  endfunction

  // Config in force after n edges: the newest one whose frame boundary has passed.
  function automatic mcfg_t active_at(input int unsigned n);
    mcfg_t r;
    r.dig = '0; r.dp = '0; r.en = '0; r.br = '0; r.acc = 0;
    foreach (acc_q[i]) if (next_wrap(acc_q[i].acc) <= n) r = acc_q[i];
    return r;
  endfunction

  function automatic bit ready_at(input int unsigned n);
    foreach (acc_q[i]) if (n >= acc_q[i].acc && n <= next_wrap(acc_q[i].acc)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit blanked(input mcfg_t c, input int unsigned d);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    return (d > 0) && ((c.dig >> (4 * d)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Per-cycle comparison of every output against the reference.
  always @(negedge ACLK) begin
    int unsigned n, t, st, d;
    mcfg_t c;
    logic [3:0] e_an, nib;
    logic [6:0] e_seg;
    logic e_dp, e_fs, lit;
    n = cyc;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    if (!ARESET && n > 0) begin
      t  = (n - 1) / TD;
      st = t % 16;
      d  = (t / 16) % 4;
      c  = active_at(n - 1);
      lit = (st >= 1) && (st <= c.br) && c.en[d] && !blanked(c, d);
      nib = 4'(c.dig >> (4 * d));
      if (lit) begin
        e_an[d] = 1'b0;
        e_seg   = seg_tab[nib];
        e_dp    = ~c.dp[d];
      end
      e_fs = (n % F) == 0;
    end
    check_eq("an", an, e_an);
    check_eq("seg", seg, e_seg);
    check_eq("dp_n", dp_n, e_dp);
    check_eq("frame_start", frame_start, e_fs);
    check_eq("cfg_ready", cfg_ready, (ARESET || n == 0) ? 1'b1 : ready_at(n));
  end

  // Offer a config once the reference says the slot is free; called at a negedge.
  task automatic send_cfg(input logic [15:0] dg, input logic [3:0] dp, input logic [3:0] en,
                          input logic [3:0] br);
    mcfg_t m;
    int unsigned w = 0;
    while (!ready_at(cyc) && w < 3 * F) begin
      @(negedge ACLK);
      w++;
    end
    check_eq("cfg_ready_at_offer", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_digits = dg; cfg_dp = dp; cfg_digit_en = en; cfg_bright = br;
    m.dig = dg; m.dp = dp; m.en = en; m.br = br; m.acc = cyc + 1;
    acc_q.push_back(m);
    @(negedge ACLK);
    cfg_valid = 1'b0;
    cfg_digits = 16'($urandom); cfg_dp = 4'($urandom);
    cfg_digit_en = 4'($urandom); cfg_bright = 4'($urandom);
  endtask

  task automatic wait_phase(input int unsigned r);
    int unsigned w = 0;
    @(negedge ACLK);
    while ((cyc % F) != r && w < 2 * F) begin
      @(negedge ACLK);
      w++;
    end
  endtask

  initial begin
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    repeat (10 * F) @(negedge ACLK);

    send_cfg(16'hFFFF, 4'h0, 4'hF, 4'd15);
    repeat (2 * F) @(negedge ACLK);
    send_cfg(16'hABCD, 4'h5, 4'hF, 4'd4);
    repeat (2 * F) @(negedge ACLK);

    // Accept during the frame_start cycle, then during the wrap-tick cycle.
    wait_phase(0);
    send_cfg(16'h1234, 4'h3, 4'hF, 4'd9);
    repeat (2 * F) @(negedge ACLK);
    wait_phase(F - 1);
    send_cfg(16'h5E6F, 4'hA, 4'hB, 4'd1);
    repeat (2 * F) @(negedge ACLK);

    send_cfg(16'h0007, 4'hF, 4'hF, 4'd15);
    repeat (2 * F) @(negedge ACLK);
    send_cfg(16'h0090, 4'hF, 4'hF, 4'd14);
    repeat (2 * F) @(negedge ACLK);
    send_cfg(16'h8888, 4'hF, 4'hF, 4'd0);
    repeat (2 * F) @(negedge ACLK);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, F)) @(negedge ACLK);
      send_cfg(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end
    repeat (2 * F) @(negedge ACLK);

    // Mid-slot reset while a config is pending.
    send_cfg(16'h8888, 4'hF, 4'hF, 4'd15);
    wait_phase(2);
    send_cfg(16'h0123, 4'h1, 4'hF, 4'd15);
    repeat (F / 2 + 8 * TD) @(negedge ACLK);
    @(posedge ACLK);
    #2 ARESET = 1'b1;
    acc_q.delete();
    #1;
    check_eq("rst_an", an, 4'hF);
    check_eq("rst_seg", seg, 7'h7F);
    check_eq("rst_dp_n", dp_n, 1'b1);
    check_eq("rst_frame_start", frame_start, 1'b0);
    check_eq("rst_cfg_ready", cfg_ready, 1'b1);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    repeat (3 * F) @(negedge ACLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
